sw_job_ctrl: RTL and testbench



---
 rtl/sw_pkg.sv | 48 ++++
 rtl/sw_job_fifo.sv | 61 ++++++
 rtl/sw_job_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sw_job_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared FSM encoding, job-entry layout and PE constant derivation
package sw_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } sw_state_t;

    // Fields are 32 bits wide; callers keep the low CALC_BIT bits (two's complement wraps correctly).
    typedef struct packed {
        logic [31:0] match;
        logic [31:0] mismatch;
        logic [31:0] alpha;
        logic [31:0] beta;
        logic [31:0] a2;
        logic [31:0] ab;
        logic [31:0] ma_a;
        logic [31:0] mis_a;
    } sw_const_t;

    // Entry layout, MSB first: {mode, tag, match, mismatch, alpha, beta}.
    function automatic int entry_width(input int match_bit, input int tag_bit);
        return 1 + tag_bit + 4 * match_bit;
    endfunction

    function automatic sw_const_t derive_consts(input logic [31:0] match,
                                                input logic [31:0] mismatch,
                                                input logic [31:0] alpha,
                                                input logic [31:0] beta,
                                                input logic        linear);
        sw_const_t   d;
        logic [31:0] beta_eff;
        beta_eff   = linear ? alpha : beta;
        d.match    = match;
        d.mismatch = -mismatch;
        d.alpha    = -alpha;
        d.beta     = -beta_eff;
        d.a2       = -(alpha << 1);
        d.ab       = -(alpha + beta_eff);
        d.ma_a     = match - alpha;
        d.mis_a    = -(mismatch + alpha);
        return d;
    endfunction

endpackage

// File: rtl/sw_job_fifo.sv
// rtl/sw_job_fifo.sv - synchronous job FIFO with push, pop, flush, full and empty
module sw_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_next_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);

    // A flush wins over any same-cycle push or pop.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    assign empty_next_o = (wr_d == rd_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sw_job_ctrl.sv
// rtl/sw_job_ctrl.sv - Smith-Waterman job controller: job queue, PE constants, start/done sequencing
module sw_job_ctrl
    import sw_pkg::*;
#(
    parameter int MATCH_BIT   = 8,
    parameter int CALC_BIT    = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int TAG_BIT     = 4,
    parameter int ARM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [MATCH_BIT-1:0] match_i,
    input  logic [MATCH_BIT-1:0] mismatch_i,
    input  logic [MATCH_BIT-1:0] alpha_i,
    input  logic [MATCH_BIT-1:0] beta_i,
    input  logic                mode_i,
    input  logic [TAG_BIT-1:0]  tag_i,
    input  logic                flush_i,
    output logic                start_o,
    input  logic                array_busy_i,
    input  logic [CALC_BIT-1:0] max_result_i,
    output logic [CALC_BIT-1:0] match_o,
    output logic [CALC_BIT-1:0] mismatch_o,
    output logic [CALC_BIT-1:0] alpha_o,
    output logic [CALC_BIT-1:0] beta_o,
    output logic [CALC_BIT-1:0] a2_o,
    output logic [CALC_BIT-1:0] ab_o,
    output logic [CALC_BIT-1:0] ma_a_o,
    output logic [CALC_BIT-1:0] mis_a_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [TAG_BIT-1:0]  done_tag_o,
    output logic [CALC_BIT-1:0] done_score_o,
    output logic                timeout_o
);

    if (CALC_BIT < MATCH_BIT + 2 || CALC_BIT > 32) begin : g_bad_calc_bit
        $error("sw_job_ctrl: CALC_BIT must be in [MATCH_BIT+2, 32]");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sw_job_ctrl: QUEUE_DEPTH must be a power of two >= 2");
    end
    if (ARM_TIMEOUT < 1) begin : g_bad_timeout
        $error("sw_job_ctrl: ARM_TIMEOUT must be >= 1");
    end

    localparam int EW  = entry_width(MATCH_BIT, TAG_BIT);
    localparam int ACW = $clog2(ARM_TIMEOUT + 1);
    localparam int KW  = 8 * CALC_BIT;
    localparam logic [ACW-1:0]      ARM_LIM = ACW'(ARM_TIMEOUT);
    localparam logic [CALC_BIT-1:0] K_ZERO  = '0;
    localparam logic [CALC_BIT-1:0] K_ONES  = '1;
    // Order: match, mismatch, alpha, beta, a2, ab, ma_a, mis_a.
    localparam logic [KW-1:0] K_RST = {K_ZERO, K_ONES, K_ONES, K_ONES, K_ONES, K_ONES, K_ZERO, K_ONES};

    logic [EW-1:0]        fifo_wdata, fifo_rdata;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_empty_next;
    logic                 q_mode;
    logic [TAG_BIT-1:0]   q_tag;
    logic [MATCH_BIT-1:0] q_match, q_mismatch, q_alpha, q_beta;
    sw_const_t            dc;
    logic                 unused_dc;

    sw_state_t            state_q, state_d;
    logic [ACW-1:0]       arm_cnt_q, arm_cnt_d;
    logic                 start_q, start_d, done_q, done_d, timeout_q, timeout_d, busy_q, busy_d;
    logic [TAG_BIT-1:0]   tag_q, tag_d, done_tag_q, done_tag_d;
    logic [CALC_BIT-1:0]  score_q, score_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 can_pop;

    assign cmd_ready_o = ~fifo_full & ~flush_i;
    assign fifo_push   = cmd_valid_i & cmd_ready_o;
    assign fifo_wdata  = {mode_i, tag_i, match_i, mismatch_i, alpha_i, beta_i};
    assign {q_mode, q_tag, q_match, q_mismatch, q_alpha, q_beta} = fifo_rdata;

    sw_job_fifo #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .flush_i      (flush_i),
        .wdata_i      (fifo_wdata),
        .rdata_o      (fifo_rdata),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .empty_next_o (fifo_empty_next)
    );

    assign dc        = derive_consts(32'(q_match), 32'(q_mismatch), 32'(q_alpha), 32'(q_beta), q_mode);
    assign unused_dc = ^dc;

    // A flushed queue must never launch, even if it held an entry this cycle.
    assign can_pop = ~fifo_empty & ~flush_i;

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        tag_d      = tag_q;
        done_tag_d = done_tag_q;
        score_d    = score_q;
        k_d        = k_q;
        fifo_pop   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (can_pop) begin
                    fifo_pop  = 1'b1;
                    state_d   = S_LAUNCH;
                    start_d   = 1'b1;
                    timeout_d = 1'b0;
                    tag_d     = q_tag;
                    k_d       = {dc.match[CALC_BIT-1:0], dc.mismatch[CALC_BIT-1:0],
                                 dc.alpha[CALC_BIT-1:0], dc.beta[CALC_BIT-1:0],
                                 dc.a2[CALC_BIT-1:0],    dc.ab[CALC_BIT-1:0],
                                 dc.ma_a[CALC_BIT-1:0],  dc.mis_a[CALC_BIT-1:0]};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d   = S_ARM;
                arm_cnt_d = '0;
            end
            S_ARM: begin
                if (array_busy_i) begin
                    state_d = S_RUN;
                end else if (arm_cnt_q == ARM_LIM) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    done_tag_d = tag_q;
                end else begin
                    arm_cnt_d = arm_cnt_q + ACW'(1);
                end
            end
            S_RUN: begin
                if (!array_busy_i) begin
                    state_d    = S_DONE;
                    score_d    = max_result_i;
                    done_d     = 1'b1;
                    done_tag_d = tag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) | ~fifo_empty_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            arm_cnt_q  <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            tag_q      <= '0;
            done_tag_q <= '0;
            score_q    <= '0;
            k_q        <= K_RST;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            start_q    <= start_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            done_tag_q <= done_tag_d;
            score_q    <= score_d;
            k_q        <= k_d;
        end
    end

    assign start_o      = start_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = busy_q;
    assign done_tag_o   = done_tag_q;
    assign done_score_o = score_q;
    assign {match_o, mismatch_o, alpha_o, beta_o, a2_o, ab_o, ma_a_o, mis_a_o} = k_q;

endmodule

// File: tb/tb_sw_job_ctrl.sv
// tb/tb_sw_job_ctrl.sv - scoreboard testbench for sw_job_ctrl
module tb_sw_job_ctrl;
    import sw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [7:0]  match_i = '0, mismatch_i = '0, alpha_i = '0, beta_i = '0;
    logic        mode_i = 1'b0, flush_i = 1'b0;
    logic [3:0]  tag_i = '0;
    logic        start_o, array_busy_i, busy_o, done_o, timeout_o;
    logic [15:0] max_result_i;
    logic [15:0] match_o, mismatch_o, alpha_o, beta_o, a2_o, ab_o, ma_a_o, mis_a_o;
    logic [3:0]  done_tag_o;
    logic [15:0] done_score_o;

    sw_job_ctrl #(.MATCH_BIT(8), .CALC_BIT(16), .QUEUE_DEPTH(4), .TAG_BIT(4), .ARM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .match_i(match_i), .mismatch_i(mismatch_i), .alpha_i(alpha_i), .beta_i(beta_i),
        .mode_i(mode_i), .tag_i(tag_i), .flush_i(flush_i), .start_o(start_o),
        .array_busy_i(array_busy_i), .max_result_i(max_result_i),
        .match_o(match_o), .mismatch_o(mismatch_o), .alpha_o(alpha_o), .beta_o(beta_o),
        .a2_o(a2_o), .ab_o(ab_o), .ma_a_o(ma_a_o), .mis_a_o(mis_a_o),
        .busy_o(busy_o), .done_o(done_o), .done_tag_o(done_tag_o),
        .done_score_o(done_score_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] k; int trel; int pcyc; } sexp_t;
    typedef struct { logic [3:0] tag; logic to; logic [15:0] score; } dexp_t;

    sexp_t       sq[$];
    dexp_t       dq[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          last_start = 0, last_done = 0, fall_cyc = 0;
    logic [127:0] last_k = '0;
    logic        prev_busy = 1'b0;
    int          arr_run = 20;
    logic [15:0] arr_score = 16'h0;
    logic        arr_noarm = 1'b0;

    localparam logic [127:0] K_RST = 128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_0000_FFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] kfun(input int m, input int mm, input int a, input int b, input logic lin);
        sw_const_t d;
        d = derive_consts(m, mm, a, b, lin);
        return {d.match[15:0], d.mismatch[15:0], d.alpha[15:0], d.beta[15:0],
                d.a2[15:0], d.ab[15:0], d.ma_a[15:0], d.mis_a[15:0]};
    endfunction

    function automatic logic [127:0] kout();
        return {match_o, mismatch_o, alpha_o, beta_o, a2_o, ab_o, ma_a_o, mis_a_o};
    endfunction

    task automatic check_reset(input string nm);
        chk({nm, "_ready"}, cmd_ready_o, 1);
        chk({nm, "_start"}, start_o, 0);
        chk({nm, "_done"}, done_o, 0);
        chk({nm, "_timeout"}, timeout_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_tag"}, done_tag_o, 0);
        chk({nm, "_score"}, done_score_o, 0);
        chk({nm, "_consts"}, kout(), K_RST);
    endtask

    // Call just after a rising edge; returns just after the edge that accepted the job.
    task automatic push_job(input logic [3:0] tag, input int m, input int mm, input int a, input int b,
                            input logic lin, input bit es, input bit ed, input logic to,
                            input logic [15:0] sc, input int trel, input logic [127:0] kx);
        sexp_t s;
        dexp_t d;
        cmd_valid_i = 1'b1;
        tag_i = tag; match_i = 8'(m); mismatch_i = 8'(mm); alpha_i = 8'(a); beta_i = 8'(b); mode_i = lin;
        @(negedge clk);
        for (int i = 0; i < 60 && !cmd_ready_o; i++) @(negedge clk);
        chk("push_ready", cmd_ready_o, 1);
        if (es) begin s.k = kx; s.trel = trel; s.pcyc = cyc; sq.push_back(s); end
        if (ed) begin d.tag = tag; d.to = to; d.score = sc; dq.push_back(d); end
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int lim);
        for (int i = 0; i < lim && (sq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
        chk({nm, "_drain"}, sq.size() + dq.size(), 0);
    endtask

    // Array model: busy rises the cycle after start_o, stays high arr_run cycles.
    initial begin
        array_busy_i = 1'b0;
        max_result_i = 16'h0;
        forever begin
            @(negedge clk);
            if (start_o && !arr_noarm) begin
                @(posedge clk);
                #1 array_busy_i = 1'b1; max_result_i = 16'hDEAD;
                repeat (arr_run) @(posedge clk);
                #1 array_busy_i = 1'b0; max_result_i = arr_score;
            end
        end
    end

    // Monitor
    initial begin
        sexp_t s;
        dexp_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_busy && !array_busy_i) fall_cyc = cyc;
                if (start_o) begin
                    if (sq.size() == 0) chk("unexpected_start", start_o, 0);
                    else begin
                        s = sq.pop_front();
                        chk("start_consts", kout(), s.k);
                        chk("start_timeout_clear", timeout_o, 0);
                        if (s.trel == 1) chk("start_after_push", cyc, s.pcyc + 2);
                        if (s.trel == 2) chk("start_after_done", cyc, last_done + 1);
                        last_k = s.k;
                    end
                    last_start = cyc;
                end
                if (done_o) begin
                    if (dq.size() == 0) chk("unexpected_done", done_o, 0);
                    else begin
                        d = dq.pop_front();
                        chk("done_tag", done_tag_o, d.tag);
                        chk("done_timeout", timeout_o, d.to);
                        chk("done_consts_stable", kout(), last_k);
                        if (d.to) chk("timeout_latency", cyc, last_start + 17);
                        else begin
                            chk("done_after_fall", cyc, fall_cyc + 1);
                            chk("done_score", done_score_o, d.score);
                        end
                    end
                    last_done = cyc;
                end
            end
            prev_busy = array_busy_i;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Affine job, 20-cycle run, score 0x0123
        arr_run = 20; arr_score = 16'h0123;
        push_job(4'h1, 2, 3, 4, 1, 1'b0, 1, 1, 1'b0, 16'h0123, 1,
                 128'h0002_FFFD_FFFC_FFFF_FFF8_FFFB_FFFE_FFF9);
        wait_drain("affine", 100);

        // Linear mode: beta := alpha
        @(posedge clk); #1;
        arr_run = 5; arr_score = 16'h0042;
        push_job(4'h2, 2, 3, 4, 1, 1'b1, 1, 1, 1'b0, 16'h0042, 1,
                 128'h0002_FFFD_FFFC_FFFC_FFF8_FFF8_FFFE_FFF9);
        wait_drain("linear", 100);

        // Array never arms, then a normal job clears timeout_o
        @(posedge clk); #1;
        arr_noarm = 1'b1;
        push_job(4'h7, 9, 1, 2, 3, 1'b0, 1, 1, 1'b1, 16'h0, 1, kfun(9, 1, 2, 3, 1'b0));
        wait_drain("timeout", 100);
        @(negedge clk);
        chk("timeout_sticky", timeout_o, 1);
        @(posedge clk); #1;
        arr_noarm = 1'b0; arr_run = 4; arr_score = 16'h0055;
        push_job(4'h8, 5, 6, 7, 8, 1'b0, 1, 1, 1'b0, 16'h0055, 1, kfun(5, 6, 7, 8, 1'b0));
        wait_drain("after_timeout", 100);

        // Five back-to-back jobs into a 4-deep queue
        @(posedge clk); #1;
        arr_run = 3; arr_score = 16'h0BEE;
        for (int i = 0; i < 5; i++)
            push_job(4'(i), i + 1, i, i + 2, 7 - i, 1'(i), 1, 1, 1'b0, 16'h0BEE, (i == 0) ? 1 : 2,
                     kfun(i + 1, i, i + 2, 7 - i, 1'(i)));
        @(negedge clk);
        chk("full_ready_low", cmd_ready_o, 0);
        wait_drain("five", 300);

        // Flush during RUN with three jobs queued
        @(posedge clk); #1;
        arr_run = 20; arr_score = 16'h0077;
        push_job(4'h9, 1, 1, 1, 1, 1'b0, 1, 1, 1'b0, 16'h0077, 1, kfun(1, 1, 1, 1, 1'b0));
        for (int i = 0; i < 3; i++) push_job(4'(10 + i), 3, 3, 3, 3, 1'b0, 0, 0, 1'b0, 16'h0, 0, '0);
        repeat (8) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", cmd_ready_o, 0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!done_o && n < 60) begin @(negedge clk); n++; end
            chk("flush_done_seen", done_o, 1);
            @(negedge clk);
            chk("flush_busy_fall", busy_o, 0);
        end
        repeat (30) @(posedge clk);
        wait_drain("flush", 10);

        // Reset mid-RUN: no done, queued job lost
        @(posedge clk); #1;
        arr_run = 20; arr_score = 16'h0099;
        push_job(4'hC, 4, 4, 4, 4, 1'b0, 1, 0, 1'b0, 16'h0, 1, kfun(4, 4, 4, 4, 1'b0));
        push_job(4'hD, 5, 5, 5, 5, 1'b0, 0, 0, 1'b0, 16'h0, 0, '0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("post_reset_busy", busy_o, 0);
        chk("final_start_q", sq.size(), 0);
        chk("final_done_q", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "simulation time limit");
    end

endmodule
